// File: rtl/tqvp_reg_arbiter.sv
// tqvp_reg_arbiter: two-requester arbiter and sequencer for the peripheral register port.
// Define ARB_FIXED_PRIO_EN to make m0 always win a tie instead of using round-robin.
module tqvp_reg_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              data_write,
  input  logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] WAIT_LD =
    3'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam bit NO_WAIT = (RD_WAIT == 0);

  state_t     state_q;
  state_t     state_d;
  logic       we_q;
  logic       sel_q;
  logic [2:0] cnt_q;
  logic       any_req;
  logic       win;
  logic       sample;
  logic       to_done;

  assign any_req = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
  assign win = m1_req & ~m0_req;
`else
  // prio_q names the requester that wins a tie
  logic prio_q;

  assign win = m1_req & (~m0_req | prio_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      prio_q <= ~win;
    end
  end
`endif

  assign busy = (state_q != IDLE);

  assign sample =
    (state_q == ACCESS && !we_q && NO_WAIT) ||
    (state_q == WAIT && cnt_q == 3'd0);

  assign to_done =
    (state_d == DONE) && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = (we_q || NO_WAIT) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      cnt_q      <= 3'd0;
      address    <= '0;
      data_in    <= '0;
      data_write <= 1'b0;
      grant      <= 2'b00;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      data_write <= 1'b0;
      m0_ack     <= to_done & ~sel_q;
      m1_ack     <= to_done & sel_q;
      if (state_q == IDLE && any_req) begin
        sel_q      <= win;
        we_q       <= win ? m1_we : m0_we;
        address    <= win ? m1_addr : m0_addr;
        data_in    <= win ? m1_wdata : m0_wdata;
        data_write <= win ? m1_we : m0_we;
        grant      <= {win, ~win};
      end
      if (state_q == ACCESS) begin
        cnt_q <= WAIT_LD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (state_q == DONE) begin
        grant <= 2'b00;
      end
      if (sample && !sel_q) begin
        m0_rdata <= data_out;
      end
      if (sample && sel_q) begin
        m1_rdata <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// tb_tqvp_reg_arbiter: two arbiters (RD_WAIT=1 and RD_WAIT=0), each with a
// register-file peripheral, checked against a transaction-level model.
module tb_tqvp_reg_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic       req [2][2];
  logic       we  [2][2];
  logic [3:0] addr[2][2];
  logic [7:0] wd  [2][2];
  logic       ack [2][2];
  logic [7:0] rd  [2][2];

  logic [3:0] address   [2];
  logic [7:0] data_in   [2];
  logic [7:0] data_out  [2];
  logic       data_write[2];
  logic [1:0] grant     [2];
  logic       busy      [2];

  logic [7:0] pmem[2][16];
  logic       loaded = 1'b0;

  logic [7:0] ref_mem[2][16];
  logic [7:0] hold[2][2];
  int         fav[2];
  int         rdw[2] = '{1, 0};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tqvp_reg_arbiter #(.RD_WAIT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0][0]), .m0_we(we[0][0]),
    .m0_addr(addr[0][0]), .m0_wdata(wd[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rd[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]),
    .m1_addr(addr[0][1]), .m1_wdata(wd[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rd[0][1]),
    .address(address[0]), .data_in(data_in[0]),
    .data_write(data_write[0]), .data_out(data_out[0]),
    .grant(grant[0]), .busy(busy[0])
  );

  tqvp_reg_arbiter #(.RD_WAIT(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[1][0]), .m0_we(we[1][0]),
    .m0_addr(addr[1][0]), .m0_wdata(wd[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rd[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]),
    .m1_addr(addr[1][1]), .m1_wdata(wd[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rd[1][1]),
    .address(address[1]), .data_in(data_in[1]),
    .data_write(data_write[1]), .data_out(data_out[1]),
    .grant(grant[1]), .busy(busy[1])
  );

  function automatic logic [7:0] pat(int a);
    return 8'(8'hC3 ^ (a * 17));
  endfunction

  // Peripheral: register file loaded once, written on the strobe
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 16; a++)
          pmem[i][a] <= pat(a);
      loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (data_write[i])
          pmem[i][address[i]] <= data_in[i];
    end
  end

  assign data_out[0] = pmem[0][address[0]];
  assign data_out[1] = pmem[1][address[1]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(int i, logic [1:0] m);
    if (m == 2'b01) return 0;
    if (m == 2'b10) return 1;
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return fav[i];
`endif
  endfunction

  // Called at the negedge of the sampling cycle with req[i][r] high;
  // returns at the negedge of the idle cycle after the ack.
  task automatic serve(input int i, input int r);
    int         lat;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    w   = we[i][r];
    a   = addr[i][r];
    d   = wd[i][r];
    lat = w ? 2 : 2 + rdw[i];
    chk("idle_busy", busy[i], 0);
    chk("idle_grant", grant[i], 0);
    chk("idle_ack", ack[i][0] | ack[i][1], 0);
    fav[i] = 1 - r;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("busy", busy[i], 1);
      chk("grant", grant[i], r ? 2'b10 : 2'b01);
      chk("strobe", data_write[i], (c == 1) && w);
      if (c == 1) chk("address", address[i], a);
      if (c == 1 && w) chk("data_in", data_in[i], d);
      if (c == lat) begin
        if (w) ref_mem[i][a] = d;
        else hold[i][r] = ref_mem[i][a];
        req[i][r] = 1'b0;
      end
      chk("ack_owner", ack[i][r], c == lat);
      chk("ack_other", ack[i][1-r], 0);
      chk("rdata0", rd[i][0], hold[i][0]);
      chk("rdata1", rd[i][1], hold[i][1]);
    end
    @(negedge clk);
  endtask

  task automatic round(input int i, input logic [1:0] m);
    int f;
    for (int q = 0; q < 2; q++) begin
      if (m[q]) begin
        req[i][q]  = 1'b1;
        we[i][q]   = 1'($urandom_range(0, 1));
        addr[i][q] = 4'($urandom_range(0, 15));
        wd[i][q]   = 8'($urandom);
      end
    end
    f = winner(i, m);
    serve(i, f);
    if (m == 2'b11) serve(i, 1 - f);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fav[i] = 0;
      for (int q = 0; q < 2; q++) hold[i][q] = 8'h00;
    end
  endtask

  initial begin
    int         got[$];
    int         e;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 16; a++) ref_mem[i][a] = pat(a);
      for (int q = 0; q < 2; q++) begin
        req[i][q]  = 1'b1;
        we[i][q]   = 1'b1;
        addr[i][q] = 4'hF;
        wd[i][q]   = 8'hFF;
      end
    end
    model_reset();

    // Reset held 2 clocks with all requests high
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_grant", grant[i], 0);
      chk("rst_strobe", data_write[i], 0);
      chk("rst_address", address[i], 0);
      chk("rst_data_in", data_in[i], 0);
      chk("rst_ack", {ack[i][0], ack[i][1]}, 0);
      chk("rst_rdata", {rd[i][0], rd[i][1]}, 0);
    end
    for (int i = 0; i < 2; i++)
      for (int q = 0; q < 2; q++) req[i][q] = 1'b0;
    rst_n = 1'b1;

    // m0 write 3 <- A5
    req[0][0] = 1'b1; we[0][0] = 1'b1;
    addr[0][0] = 4'h3; wd[0][0] = 8'hA5;
    serve(0, 0);

    // m0 write 7 <- 5C, then m1 read of 7 with one wait cycle
    req[0][0] = 1'b1; we[0][0] = 1'b1;
    addr[0][0] = 4'h7; wd[0][0] = 8'h5C;
    serve(0, 0);
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 4'h7;
    serve(0, 1);
    chk("m1_rdata_5c", rd[0][1], 8'h5C);

    // Both requesters re-requesting continuously
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    we[0][0] = 1'b1; we[0][1] = 1'b1;
    for (int cyc = 0; cyc < 60 && got.size() < 4; cyc++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        if (!req[0][q]) begin
          req[0][q]  = 1'b1;
          addr[0][q] = 4'($urandom_range(0, 15));
          wd[0][q]   = 8'($urandom);
        end else if (ack[0][q]) begin
          got.push_back(q);
          ref_mem[0][addr[0][q]] = wd[0][q];
          req[0][q] = 1'b0;
        end
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    chk("alt_count", got.size(), 4);
    e = winner(0, 2'b11);
    for (int n = 0; n < 4; n++) begin
      if (n < got.size()) chk("alt_order", got[n], e);
      fav[0] = 1 - e;
      e = winner(0, 2'b11);
    end
    @(negedge clk);

    // Reset during the ACCESS cycle of a write
    req[0][0] = 1'b1; we[0][0] = 1'b1;
    addr[0][0] = 4'h9; wd[0][0] = 8'h3C;
    @(negedge clk);
    chk("ra_strobe", data_write[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ra_busy", busy[0], 0);
    chk("ra_strobe_off", data_write[0], 0);
    chk("ra_grant", grant[0], 0);
    chk("ra_ack", {ack[0][0], ack[0][1]}, 0);
    ref_mem[0][9] = 8'h3C;
    model_reset();
    req[0][0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ra_no_ack", {ack[0][0], ack[0][1]}, 0);
    chk("ra_idle", busy[0], 0);

    // RD_WAIT=0: m0 read then m1 write to the same register
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 4'h5;
    serve(1, 0);
    chk("b2b_rdata", rd[1][0], pat(5));
    req[1][1] = 1'b1; we[1][1] = 1'b1;
    addr[1][1] = 4'h5; wd[1][1] = 8'h77;
    serve(1, 1);
    chk("b2b_hold", rd[1][0], pat(5));

    // Random traffic on both instances
    for (int n = 0; n < 80; n++) begin
      round($urandom_range(0, 1), 2'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
